// File: rtl/mem_access_unit.sv
// Load/store unit between the EX stage and a single-outstanding request/ack bus.
// Checks alignment, builds byte enables and replicated store data, and extracts and extends load lanes.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_en,
    input  logic        mem_flush,
    input  logic        ex_en,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        mem_stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [3:0]  exp_code
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        ld_valid_q, ld_valid_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [3:0]  exp_code_q, exp_code_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic        discard_q, discard_d;

    logic        op_valid, op_load, op_half, op_word, misaligned, accept;
    logic        load_q;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, lane, ld_ext;

    always_comb begin
        op_valid   = (ex_mem_op >= 4'd1) && (ex_mem_op <= 4'd8);
        op_load    = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LHU);
        op_half    = (ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH);
        op_word    = (ex_mem_op == OP_LW) || (ex_mem_op == OP_SW);
        misaligned = (op_half && ex_addr[0]) || (op_word && (ex_addr[1:0] != 2'b00));
        accept     = ex_en && op_valid && (state_q == ST_IDLE) && !mem_flush;
        load_q     = (op_q >= OP_LB) && (op_q <= OP_LHU);
        if (op_word) begin
            be_new    = 4'b1111;
            wdata_new = ex_store_data;
        end else if (op_half) begin
            be_new    = 4'b0011 << ex_addr[1:0];
            wdata_new = {2{ex_store_data[15:0]}};
        end else begin
            be_new    = 4'b0001 << ex_addr[1:0];
            wdata_new = {4{ex_store_data[7:0]}};
        end
        lane = bus_rdata >> {off_q, 3'b000};
        case (op_q)
            OP_LB:   ld_ext = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  ld_ext = {24'd0, lane[7:0]};
            OP_LH:   ld_ext = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  ld_ext = {16'd0, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    // Bus handshake: bus_req and its qualifiers stay stable until a one-cycle
    // bus_ack is sampled (or the timeout fires); the request drops on that edge.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        ld_valid_d  = ld_valid_q;
        ld_data_d   = ld_data_q;
        exp_code_d  = exp_code_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        off_d       = off_q;
        discard_d   = discard_q;
        if (cpu_en) begin
            ld_valid_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            exp_code_d = op_load ? 4'd4 : 4'd6;
                        end else begin
                            state_d     = ST_BUS;
                            bus_req_d   = 1'b1;
                            bus_we_d    = !op_load;
                            bus_addr_d  = {ex_addr[31:2], 2'b00};
                            bus_be_d    = be_new;
                            bus_wdata_d = wdata_new;
                            op_d        = ex_mem_op;
                            off_d       = ex_addr[1:0];
                            cnt_d       = 8'd0;
                            discard_d   = 1'b0;
                            exp_code_d  = 4'd0;
                        end
                    end
                end
                ST_BUS: begin
                    // A flush arriving on the final bus cycle still discards this op.
                    discard_d = discard_q | mem_flush;
                    if (bus_ack) begin
                        state_d   = ST_RESP;
                        bus_req_d = 1'b0;
                        if (load_q) begin
                            ld_data_d  = ld_ext;
                            ld_valid_d = !discard_d;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_d   = ST_RESP;
                        bus_req_d = 1'b0;
                        if (!discard_d) begin
                            exp_code_d = load_q ? 4'd5 : 4'd7;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_d   = ST_IDLE;
                    discard_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'd0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= 32'd0;
            exp_code_q  <= 4'd0;
            cnt_q       <= 8'd0;
            op_q        <= 4'd0;
            off_q       <= 2'd0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            exp_code_q  <= exp_code_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            off_q       <= off_d;
            discard_q   <= discard_d;
        end
    end

    assign mem_stall = ((state_q == ST_IDLE) && accept && !misaligned) || (state_q == ST_BUS);
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign ld_valid  = ld_valid_q;
    assign ld_data   = ld_data_q;
    assign exp_code  = exp_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level reference model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_en = 1'b1;
    logic        mem_flush = 1'b0;
    logic        ex_en = 1'b0;
    logic [3:0]  ex_mem_op = 4'd0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_store_data = 32'd0;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ack = 1'b0;
    logic        bus_req, bus_we, mem_stall, ld_valid;
    logic [31:0] bus_addr, bus_wdata, ld_data;
    logic [3:0]  bus_be, exp_code;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  model_code = 4'd0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .mem_flush(mem_flush),
        .ex_en(ex_en), .ex_mem_op(ex_mem_op), .ex_addr(ex_addr),
        .ex_store_data(ex_store_data), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .mem_stall(mem_stall),
        .ld_valid(ld_valid), .ld_data(ld_data), .exp_code(exp_code)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_valid(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic bit ref_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic int ref_size(input logic [3:0] op);
        case (op)
            4'd2, 4'd5, 4'd7: return 2;
            4'd3, 4'd8:       return 4;
            default:          return 1;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] addr);
        int sz = ref_size(op);
        if (sz == 4) return 4'hF;
        return 4'(((sz == 1) ? 1 : 3) << (addr % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] d);
        int sz = ref_size(op);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v = rdata >> ((addr % 4) * 8);
        case (op)
            4'd1: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v | 32'hFFFF_FF00; end
            4'd2: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v | 32'hFFFF_0000; end
            4'd4: v = v & 32'hFF;
            4'd5: v = v & 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    // ack_dly: bus cycle (1-based) in which ack is driven; 0 or >TO means never.
    // flush_at: bus cycle in which mem_flush is pulsed; 0 means none.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int ack_dly, input int flush_at);
        bit mis       = ref_valid(op) && ((addr % ref_size(op)) != 0);
        bit go        = ref_valid(op) && !mis;
        bit acked     = (ack_dly >= 1) && (ack_dly <= TO);
        int exp_bus   = acked ? ack_dly : TO;
        bit disc      = (flush_at >= 1) && (flush_at <= exp_bus);
        bit exp_ldv   = ref_is_load(op) && acked && !disc;
        int bus_cyc   = 0;
        int stall_cyc = 0;
        int ldv_cnt   = 0;
        bit done      = 1'b0;
        @(negedge clk);
        ex_en = 1'b1; ex_mem_op = op; ex_addr = addr; ex_store_data = sdata;
        mem_flush = 1'b0; bus_ack = 1'b0;
        #1 check_eq("stall_accept", 32'(mem_stall), 32'(go));
        @(negedge clk);
        if (!go) begin
            check_eq("no_bus_req", 32'(bus_req), 32'd0);
            if (mis) model_code = ref_is_load(op) ? 4'd4 : 4'd6;
            check_eq("code_idle_op", 32'(exp_code), 32'(model_code));
            ex_en = 1'b0;
            #1 check_eq("stall_idle", 32'(mem_stall), 32'd0);
            return;
        end
        if (exp_ldv) exp_q.push_back(ref_load(op, addr, rdata));
        model_code = (!acked && !disc) ? (ref_is_load(op) ? 4'd5 : 4'd7) : 4'd0;
        for (int c = 0; c < TO + 10 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (ld_valid) begin
                ldv_cnt++;
                if (exp_q.size() > 0) check_eq("ld_data", ld_data, exp_q.pop_front());
            end
            if (bus_req) begin
                bus_cyc++;
                check_eq("bus_addr", bus_addr, {addr[31:2], 2'b00});
                check_eq("bus_be", 32'(bus_be), 32'(ref_be(op, addr)));
                check_eq("bus_we", 32'(bus_we), 32'(!ref_is_load(op)));
                if (!ref_is_load(op)) check_eq("bus_wdata", bus_wdata, ref_wdata(op, sdata));
                bus_ack   = (bus_cyc == ack_dly);
                bus_rdata = bus_ack ? rdata : $urandom;
                mem_flush = (bus_cyc == flush_at);
                ex_en     = 1'($urandom_range(0, 1));
                ex_mem_op = 4'($urandom);
                ex_addr   = $urandom;
            end else begin
                done = 1'b1;
                bus_ack = 1'b0; mem_flush = 1'b0; ex_en = 1'b0;
                check_eq("exp_code_resp", 32'(exp_code), 32'(model_code));
            end
            #1 if (mem_stall) stall_cyc++;
        end
        check_eq("resp_reached", 32'(done), 32'd1);
        check_eq("bus_cycles", bus_cyc, exp_bus);
        check_eq("stall_cycles", stall_cyc, exp_bus);
        check_eq("ld_valid_cnt", ldv_cnt, 32'(exp_ldv));
        @(negedge clk);
        check_eq("ld_valid_drop", 32'(ld_valid), 32'd0);
        check_eq("code_hold", 32'(exp_code), 32'(model_code));
    endtask

    task automatic reset_mid_bus();
        @(negedge clk);
        ex_en = 1'b1; ex_mem_op = 4'd1; ex_addr = 32'h0000_1003;
        @(negedge clk);
        ex_en = 1'b0;
        check_eq("rst_pre_req", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_req", 32'(bus_req), 32'd0);
        check_eq("rst_async_be", 32'(bus_be), 32'd0);
        check_eq("rst_async_addr", bus_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_ack = 1'b0;
        check_eq("late_ack_req", 32'(bus_req), 32'd0);
        check_eq("late_ack_ldv", 32'(ld_valid), 32'd0);
        check_eq("late_ack_code", 32'(exp_code), 32'd0);
        #1 check_eq("late_ack_idle", 32'(mem_stall), 32'd0);
        model_code = 4'd0;
    endtask

    task automatic cpu_en_freeze();
        @(negedge clk);
        cpu_en = 1'b0; ex_en = 1'b1; ex_mem_op = 4'd3; ex_addr = 32'h0000_3001;
        @(negedge clk);
        check_eq("frz_code", 32'(exp_code), 32'(model_code));
        ex_mem_op = 4'd8; ex_addr = 32'h0000_0100;
        @(negedge clk);
        check_eq("frz_req", 32'(bus_req), 32'd0);
        ex_en = 1'b0; cpu_en = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_req", 32'(bus_req), 32'd0);
        check_eq("rst_we", 32'(bus_we), 32'd0);
        check_eq("rst_addr", bus_addr, 32'd0);
        check_eq("rst_be", 32'(bus_be), 32'd0);
        check_eq("rst_wdata", bus_wdata, 32'd0);
        check_eq("rst_ldv", 32'(ld_valid), 32'd0);
        check_eq("rst_ldd", ld_data, 32'd0);
        check_eq("rst_code", 32'(exp_code), 32'd0);
        check_eq("rst_stall", 32'(mem_stall), 32'd0);
        rst_n = 1'b1;

        run_op(4'd1, 32'h0000_1003, 32'd0, 32'h80FF_FF00, 2, 0);
        run_op(4'd7, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 1, 0);
        run_op(4'd3, 32'h0000_3001, 32'd0, 32'd0, 1, 0);
        run_op(4'd8, 32'h0000_0040, 32'hCAFE_F00D, 32'd0, 0, 0);
        run_op(4'd5, 32'h0000_4002, 32'd0, 32'hBEEF_0000, 3, 2);
        run_op(4'd2, 32'h0000_5002, 32'd0, 32'h8001_0000, TO, 0);
        run_op(4'd6, 32'h0000_6003, 32'h0000_00A5, 32'd0, 1, 0);
        run_op(4'd0, 32'h0000_7000, 32'd0, 32'd0, 1, 0);
        run_op(4'd4, 32'h0000_8001, 32'd0, 32'h0000_F100, 1, 0);
        cpu_en_freeze();
        reset_mid_bus();

        for (int i = 0; i < 60; i++) begin
            logic [3:0] op = 4'($urandom_range(0, 15));
            int fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TO)) : 0;
            run_op(op, $urandom, $urandom, $urandom, int'($urandom_range(0, TO + 1)), fl);
        end

        check_eq("exp_q_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
